mem_access_unit: RTL and testbench

- Initiator side of the data-memory interface.
- Sits in the MEM stage of the pipelined multicycle processor. Accepts one load or store request at a time from the EX/MEM register.
- Converts the byte address to a word index and range-checks it. Drives single-cycle MemRead/MemWrite strobes into the data memory, waits a fixed latency, then returns the load data or store completion to writeback through a valid/ready handshake.

---
 rtl/mem_access_unit.sv | 89 ++++++++
 tb/tb_mem_access_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator that range-checks a byte address, strobes data memory once,
// waits LATENCY cycles and returns load data or store completion over a valid/ready response.
module mem_access_unit #(
  parameter int DEPTH   = 65,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic load_q, load_d, fault_q, fault_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [4:0] rd_q, rd_d;
  logic accept, bad, last;
  assign accept = state_q == IDLE && req_valid && (req_load || req_store);
  assign bad = req_addr[1:0] != 2'b0 || {2'b0, req_addr[31:2]} >= 32'(DEPTH) || (req_load && req_store);
  assign last = state_q == WAIT && cnt_q == '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   state_d = accept ? (bad ? RESP : STROBE) : IDLE;
      STROBE: state_d = WAIT;
      WAIT:   state_d = last ? RESP : WAIT;
      RESP:   state_d = resp_ready ? IDLE : RESP;
    endcase
  end
  // Address and store data only change at accept, so memory inputs are stable under any strobe.
  always_comb begin
    addr_d  = accept ? {2'b0, req_addr[31:2]} : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    rd_d    = accept ? req_rd : rd_q;
    load_d  = accept ? req_load : load_q;
    cnt_d   = state_q == STROBE ? CW'(LATENCY - 1) : (state_q == WAIT && !last) ? cnt_q - CW'(1) : cnt_q;
    fault_d = accept ? bad : (state_q == RESP && resp_ready) ? 1'b0 : fault_q;
    rdata_d = (accept && bad) ? 32'd0 : last ? (load_q ? mem_rdata : 32'd0) : rdata_q;
  end
  always_comb begin
    req_ready  = state_q == IDLE;
    resp_valid = state_q == RESP;
    mem_read   = state_q == STROBE && load_q;
    mem_write  = state_q == STROBE && !load_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    resp_rdata = rdata_q;
    resp_rd    = rd_q;
    resp_fault = fault_q;
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: two units (LATENCY 1 and 3) with behavioural memories, directed and random
// requests checked against an abstract reference model of memory contents, faults and latency.
module tb_mem_access_unit;
  localparam int DEPTH = 65;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst [2];
  logic        req_valid [2], req_ready [2], req_load [2], req_store [2];
  logic [31:0] req_addr [2], req_wdata [2];
  logic [4:0]  req_rd [2], resp_rd [2];
  logic        resp_valid [2], resp_ready [2], resp_fault [2];
  logic [31:0] resp_rdata [2], mem_addr [2], mem_wdata [2];
  logic        mem_read [2], mem_write [2];
  logic [31:0] seed [DEPTH];
  logic [31:0] ref_mem [2][DEPTH];
  logic        preload;
  int checks = 0, passes = 0;
  for (genvar g = 0; g < 2; g++) begin : u
    logic [31:0] m [DEPTH];
    logic [31:0] rdat;
    mem_access_unit #(.DEPTH(DEPTH), .LATENCY(g == 0 ? 1 : 3)) dut (
      .clk(clk), .reset(rst[g]), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_load(req_load[g]), .req_store(req_store[g]), .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]), .req_rd(req_rd[g]), .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]), .resp_rdata(resp_rdata[g]), .resp_rd(resp_rd[g]),
      .resp_fault(resp_fault[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_read(mem_read[g]), .mem_write(mem_write[g]), .mem_rdata(rdat));
    always @(posedge clk) begin
      if (preload) begin
        for (int i = 0; i < DEPTH; i++) m[i] <= seed[i];
      end else begin
        if (mem_write[g] && mem_addr[g] < DEPTH) m[mem_addr[g][6:0]] <= mem_wdata[g];
        if (mem_read[g] && mem_addr[g] < DEPTH) rdat <= m[mem_addr[g][6:0]];
      end
    end
  end
  function automatic int lat(int n);
    return n == 0 ? 1 : 3;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic txn(int n, bit ld, bit st, logic [31:0] addr, logic [31:0] wd, int hold);
    bit f;
    logic [31:0] exp_rd, got_rd;
    logic [4:0] tag;
    int cyc, nr, nw;
    f = addr[1:0] != 2'b0 || (addr >> 2) >= DEPTH || (ld && st);
    exp_rd = (f || !ld) ? 32'd0 : ref_mem[n][addr >> 2];
    if (!f && st) ref_mem[n][addr >> 2] = wd;
    tag = 5'($urandom);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[n]), 32'd1);
    req_valid[n] = 1'b1; req_load[n] = ld; req_store[n] = st;
    req_addr[n] = addr; req_wdata[n] = wd; req_rd[n] = tag;
    @(posedge clk);
    @(negedge clk);
    req_valid[n] = 1'b0; req_addr[n] = $urandom; req_wdata[n] = $urandom; req_rd[n] = 5'($urandom);
    cyc = 1; nr = 0; nw = 0;
    while (!resp_valid[n] && cyc < 20) begin
      if (mem_read[n] || mem_write[n]) chk("strobe_addr", mem_addr[n], addr >> 2);
      if (mem_write[n]) chk("strobe_wdata", mem_wdata[n], wd);
      chk("req_ready_busy", 32'(req_ready[n]), 32'd0);
      nr += int'(mem_read[n]);
      nw += int'(mem_write[n]);
      @(negedge clk);
      cyc++;
    end
    chk("resp_latency", 32'(cyc), f ? 32'd1 : 32'(2 + lat(n)));
    chk("read_pulses", 32'(nr), 32'(!f && ld));
    chk("write_pulses", 32'(nw), 32'(!f && st));
    chk("resp_rdata", resp_rdata[n], exp_rd);
    chk("resp_fault", 32'(resp_fault[n]), 32'(f));
    chk("resp_rd", 32'(resp_rd[n]), 32'(tag));
    got_rd = resp_rdata[n];
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid[n]), 32'd1);
      chk("hold_rdata", resp_rdata[n], got_rd);
      chk("hold_ready", 32'(req_ready[n]), 32'd0);
    end
    resp_ready[n] = 1'b1;
    @(negedge clk);
    resp_ready[n] = 1'b0;
    chk("resp_drop", 32'(resp_valid[n]), 32'd0);
    chk("fault_drop", 32'(resp_fault[n]), 32'd0);
  endtask
  task automatic rst_test(int n, int stage);
    @(negedge clk);
    req_valid[n] = 1'b1; req_load[n] = 1'b1; req_store[n] = 1'b0; req_addr[n] = 32'h14;
    @(posedge clk);
    @(negedge clk);
    req_valid[n] = 1'b0;
    if (stage == 2) @(negedge clk);
    chk("pre_reset_read", 32'(mem_read[n]), 32'(stage == 1));
    #2 rst[n] = 1'b1;
    #1;
    chk("reset_read_drop", 32'(mem_read[n]), 32'd0);
    chk("reset_ready", 32'(req_ready[n]), 32'd1);
    chk("reset_addr", mem_addr[n], 32'd0);
    @(negedge clk);
    rst[n] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_reset_no_resp", 32'(resp_valid[n]), 32'd0);
      chk("post_reset_no_strobe", 32'(mem_read[n] | mem_write[n]), 32'd0);
    end
  endtask
  task automatic noop_test(int n);
    @(negedge clk);
    req_valid[n] = 1'b1; req_load[n] = 1'b0; req_store[n] = 1'b0; req_addr[n] = 32'h8;
    @(posedge clk);
    @(negedge clk);
    req_valid[n] = 1'b0;
    repeat (4) begin
      chk("noop_ready", 32'(req_ready[n]), 32'd1);
      chk("noop_no_resp", 32'(resp_valid[n]), 32'd0);
      chk("noop_no_strobe", 32'(mem_read[n] | mem_write[n]), 32'd0);
      @(negedge clk);
    end
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) seed[i] = $urandom;
    seed[3] = 32'd47; seed[4] = 32'd7; seed[5] = 32'd100;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[n][i] = seed[i];
      rst[n] = 1'b1; req_valid[n] = 1'b0; req_load[n] = 1'b0; req_store[n] = 1'b0;
      req_addr[n] = '0; req_wdata[n] = '0; req_rd[n] = '0; resp_ready[n] = 1'b0;
    end
    preload = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      chk("rst_req_ready", 32'(req_ready[n]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[n]), 32'd0);
      chk("rst_resp_fault", 32'(resp_fault[n]), 32'd0);
      chk("rst_strobes", 32'(mem_read[n] | mem_write[n]), 32'd0);
      chk("rst_mem_addr", mem_addr[n], 32'd0);
      chk("rst_mem_wdata", mem_wdata[n], 32'd0);
      chk("rst_resp_rdata", resp_rdata[n], 32'd0);
      chk("rst_resp_rd", 32'(resp_rd[n]), 32'd0);
    end
    preload = 1'b0;
    rst[0] = 1'b0; rst[1] = 1'b0;
    txn(0, 1, 0, 32'h14, 0, 0);
    txn(0, 0, 1, 32'h28, 32'h7E8, 0);
    txn(0, 1, 0, 32'h28, 0, 0);
    txn(0, 1, 0, 32'h06, 0, 0);
    txn(0, 1, 0, 32'h104, 0, 0);
    txn(0, 1, 1, 32'h10, 32'h55, 0);
    txn(0, 1, 0, 32'h10, 0, 5);
    txn(0, 1, 0, 32'h100, 0, 0);
    rst_test(0, 2);
    rst_test(0, 1);
    noop_test(0);
    txn(0, 1, 0, 32'h14, 0, 1);
    txn(1, 1, 0, 32'h0C, 0, 0);
    noop_test(1);
    txn(1, 0, 1, 32'h0C, 32'hDEAD_BEEF, 2);
    txn(1, 1, 0, 32'h0C, 0, 0);
    rst_test(1, 2);
    for (int k = 0; k < 80; k++) begin
      int n, sel;
      bit ld, st;
      logic [31:0] a;
      n = k % 2;
      sel = int'($urandom_range(0, 9));
      a = sel == 0 ? $urandom : sel == 1 ? (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3))
                                         : 32'($urandom_range(0, DEPTH - 1)) << 2;
      ld = $urandom_range(0, 1) == 1;
      st = !ld || $urandom_range(0, 9) == 0;
      txn(n, ld, st, a, $urandom, int'($urandom_range(0, 3)));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
